// File: rtl/reverb_stream_pkg.sv
// Shared stream/sample widths, the stereo pair type and the word unpacker
// used by the reverb stream sink.
package reverb_stream_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

    // Left channel rides in the upper half of the stream word.
    function automatic stereo_sample_t unpack_word(input logic [WORD_W-1:0] word);
        stereo_sample_t s;
        s.left  = word[WORD_W-1:SAMPLE_W];
        s.right = word[SAMPLE_W-1:0];
        return s;
    endfunction

endpackage

// File: rtl/reverb_st_sink_fifo.sv
// Small register FIFO for stream words: push/pop/flush with count, full and empty.
// Flush wins over push and pop in the same cycle.
module reverb_st_sink_fifo
    import reverb_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reverb_st_audio_unpacker.sv
// Stream sink: buffers 32-bit words and releases one stereo pair per sample tick.
// Optional underrun counter enabled by defining REVERB_UNDERRUN_CNT_EN.
module reverb_st_audio_unpacker
    import reverb_stream_pkg::*;
#(
    parameter int DEPTH            = 4,
    parameter bit ZERO_ON_UNDERRUN = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [WORD_W-1:0]   st_data,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic                sample_tick,
    input  logic                flush,
    output logic [SAMPLE_W-1:0] left_out,
    output logic [SAMPLE_W-1:0] right_out,
    output logic                out_valid,
    output logic                underrun,
    output logic                overflow,
    output logic [15:0]         underrun_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rd_data;
    logic              ready_q;
    logic              run_q;
    logic [CNT_W:0]    occupancy;
    logic              pop_ok;
    logic              underrun_ev;
    stereo_sample_t    head;

    // Handshake (ready latency 1): st_valid may only be high in the cycle after
    // st_ready was high. ready_q remembers that a word may still be in flight,
    // so ready is withheld until stored words plus that word still fit.
    assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, ready_q};
    assign st_ready    = run_q && !flush && (occupancy < (CNT_W+1)'(DEPTH));
    assign pop_ok      = sample_tick && !flush && !fifo_empty;
    assign underrun_ev = sample_tick && (flush || fifo_empty);
    assign head        = unpack_word(fifo_rd_data);

    reverb_st_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (st_valid),
        .pop     (sample_tick),
        .flush   (flush),
        .wr_data (st_data),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // run_q keeps st_ready low for the first cycle out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            ready_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            ready_q  <= st_ready;
            overflow <= overflow | (st_valid && fifo_full && !flush);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            underrun  <= 1'b0;
            if (pop_ok) begin
                left_out  <= head.left;
                right_out <= head.right;
                out_valid <= 1'b1;
            end else if (underrun_ev) begin
                out_valid <= 1'b1;
                underrun  <= 1'b1;
                if (ZERO_ON_UNDERRUN) begin
                    left_out  <= '0;
                    right_out <= '0;
                end
            end
        end
    end

`ifdef REVERB_UNDERRUN_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (flush) begin
            underrun_count <= '0;
        end else if (underrun_ev && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_reverb_st_audio_unpacker.sv
// Directed bench for reverb_st_audio_unpacker: a zero-on-underrun instance and a
// hold-on-underrun instance share stimulus and are checked against a queue model.
module tb_reverb_st_audio_unpacker;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic [31:0] st_data;
    logic        st_valid;
    logic        sample_tick;
    logic        flush;

    logic        st_ready,  h_st_ready;
    logic [15:0] left_out,  h_left_out;
    logic [15:0] right_out, h_right_out;
    logic        out_valid, h_out_valid;
    logic        underrun,  h_underrun;
    logic        overflow,  h_overflow;
    logic [15:0] underrun_count, h_underrun_count;

    int checks   = 0;
    int failures = 0;

    reverb_st_audio_unpacker #(.DEPTH(DEPTH), .ZERO_ON_UNDERRUN(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .st_data(st_data), .st_valid(st_valid),
        .st_ready(st_ready), .sample_tick(sample_tick), .flush(flush),
        .left_out(left_out), .right_out(right_out), .out_valid(out_valid),
        .underrun(underrun), .overflow(overflow), .underrun_count(underrun_count)
    );

    reverb_st_audio_unpacker #(.DEPTH(DEPTH), .ZERO_ON_UNDERRUN(1'b0)) dut_hold (
        .clock(clock), .reset_n(reset_n), .st_data(st_data), .st_valid(st_valid),
        .st_ready(h_st_ready), .sample_tick(sample_tick), .flush(flush),
        .left_out(h_left_out), .right_out(h_right_out), .out_valid(h_out_valid),
        .underrun(h_underrun), .overflow(h_overflow), .underrun_count(h_underrun_count)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // model: a queue of stored words plus the previous expected ready
    logic [31:0] exp_q[$];
    bit          m_started, m_prev_ready, m_ovf, m_valid, m_under;
    logic [15:0] m_l0, m_r0, m_l1, m_r1;
    int          m_cnt;

    function automatic bit exp_ready();
        return m_started && !flush && ((exp_q.size() + int'(m_prev_ready)) < DEPTH);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_started = 0; m_prev_ready = 0; m_ovf = 0; m_valid = 0; m_under = 0;
            m_l0 = 0; m_r0 = 0; m_l1 = 0; m_r1 = 0; m_cnt = 0;
        end else begin
            automatic bit cur_ready = exp_ready();
            automatic int sz0 = exp_q.size();
            automatic logic [31:0] w;
            m_valid = 0;
            m_under = 0;
            if (sample_tick) begin
                m_valid = 1;
                if (flush || sz0 == 0) begin
                    m_under = 1;
                    m_l0 = 0; m_r0 = 0;
                end else begin
                    w = exp_q.pop_front();
                    m_l0 = w[31:16]; m_r0 = w[15:0];
                    m_l1 = w[31:16]; m_r1 = w[15:0];
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (st_valid) begin
                if (sz0 < DEPTH) exp_q.push_back(st_data);
                else m_ovf = 1;
            end
`ifdef REVERB_UNDERRUN_CNT_EN
            if (flush) m_cnt = 0;
            else if (m_under && m_cnt < 16'hFFFF) m_cnt++;
`endif
            m_prev_ready = cur_ready;
            m_started = 1;
        end
    end

    // compare process
    always @(negedge clock) begin
        check("st_ready", st_ready, exp_ready());
        check("h_st_ready", h_st_ready, exp_ready());
        check("out_valid", out_valid, m_valid);
        check("h_out_valid", h_out_valid, m_valid);
        check("underrun", underrun, m_under);
        check("h_underrun", h_underrun, m_under);
        check("overflow", overflow, m_ovf);
        check("h_overflow", h_overflow, m_ovf);
        check("left_out", left_out, m_l0);
        check("right_out", right_out, m_r0);
        check("h_left_out", h_left_out, m_l1);
        check("h_right_out", h_right_out, m_r1);
        check("underrun_count", underrun_count, m_cnt);
        check("h_underrun_count", h_underrun_count, m_cnt);
    end

    // driver tasks
    logic [31:0] tx_q[$];

    task automatic step();
        @(posedge clock);
        #1;
        st_valid    = 1'b0;
        sample_tick = 1'b0;
        flush       = 1'b0;
    endtask

    // Sends tx_q honouring ready latency 1; optional tick every tick_every cycles.
    task automatic push_stream(input int tick_every, output bit last_r);
        int idx = 0;
        int guard = 0;
        bit prev_r = 0;
        bit r;
        while (idx < tx_q.size() && guard < 200) begin
            r = st_ready;
            if (prev_r) begin
                st_valid = 1'b1;
                st_data  = tx_q[idx];
                idx++;
            end else begin
                st_valid = 1'b0;
            end
            sample_tick = (tick_every > 0) && ((guard % tick_every) == tick_every - 1);
            @(posedge clock);
            #1;
            prev_r = r;
            guard++;
        end
        st_valid    = 1'b0;
        sample_tick = 1'b0;
        check("stream_timeout", (guard < 200), 1);
        last_r = prev_r;
        tx_q.delete();
    endtask

    task automatic tick_expect(input logic [15:0] l, input logic [15:0] r);
        sample_tick = 1'b1;
        step();
        check("tick_out_valid", out_valid, 1);
        check("tick_underrun", underrun, 0);
        check("tick_left", left_out, l);
        check("tick_right", right_out, r);
        check("tick_h_left", h_left_out, l);
        check("tick_h_right", h_right_out, r);
    endtask

    task automatic underrun_expect(input logic [15:0] hl, input logic [15:0] hr);
        sample_tick = 1'b1;
        step();
        check("ur_out_valid", out_valid, 1);
        check("ur_underrun", underrun, 1);
        check("ur_left_zero", left_out, 0);
        check("ur_right_zero", right_out, 0);
        check("ur_h_left_held", h_left_out, hl);
        check("ur_h_right_held", h_right_out, hr);
    endtask

    initial begin
        bit last_r;
        reset_n = 1'b0; st_data = '0; st_valid = 1'b0; sample_tick = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_left", left_out, 0);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        check("ready_low_first_cycle", st_ready, 0);
        step();
        check("ready_high_after", st_ready, 1);

        // fill to DEPTH with valid following ready; ready must drop, nothing lost
        tx_q = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
        push_stream(0, last_r);
        check("full_ready_low", st_ready, 0);
        check("full_no_overflow", overflow, 0);

        // protocol violation while full: dropped, sticky overflow
        st_valid = 1'b1; st_data = 32'hDEADBEEF;
        step();
        check("overflow_set", overflow, 1);
        step();
        check("overflow_sticky", overflow, 1);

        tick_expect(16'h1111, 16'h2222);
        step();
        tick_expect(16'h3333, 16'h4444);
        tick_expect(16'h5555, 16'h6666);
        step();
        tick_expect(16'h7777, 16'h8888);
        underrun_expect(16'h7777, 16'h8888);
`ifdef REVERB_UNDERRUN_CNT_EN
        check("cnt_one", underrun_count, 1);
`else
        check("cnt_tied_zero", underrun_count, 0);
`endif

        // push and tick together at count 0: underrun, word kept
        check("ready_before_same_cycle", st_ready, 1);
        st_valid = 1'b1; st_data = 32'h0A0B0C0D; sample_tick = 1'b1;
        step();
        check("same_cycle_underrun", underrun, 1);
        check("same_cycle_left_zero", left_out, 0);
        check("same_cycle_h_left", h_left_out, 16'h7777);
        tick_expect(16'h0A0B, 16'h0C0D);

        // mixed stream with ticks, then drain
        tx_q = '{32'hA1A2B1B2, 32'hC3C4D3D4, 32'hE5E6F5F6, 32'h01020304, 32'h8000FFFF, 32'h7FFF0001};
        push_stream(3, last_r);
        for (int i = 0; i < 8; i++) begin
            sample_tick = 1'b1;
            step();
            step();
        end

        // flush with 3 buffered words; word and tick during flush
        tx_q = '{32'hAAAA5555, 32'h0123ABCD, 32'hFEDC3210};
        push_stream(0, last_r);
        flush = 1'b1; st_valid = last_r; st_data = 32'h99999999; sample_tick = 1'b1;
        step();
        check("flush_tick_underrun", underrun, 1);
        underrun_expect(16'h7FFF, 16'h0001);
        tx_q = '{32'h13572468};
        push_stream(0, last_r);
        tick_expect(16'h1357, 16'h2468);

        // asynchronous reset mid-transfer
        st_valid = 1'b1; st_data = 32'h24681357;
        #2 reset_n = 1'b0;
        #1;
        check("arst_ready", st_ready, 0);
        check("arst_left", left_out, 0);
        check("arst_right", right_out, 0);
        check("arst_h_left", h_left_out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_underrun", underrun, 0);
        check("arst_overflow", overflow, 0);
        check("arst_count", underrun_count, 0);
        st_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("rerst_ready_low", st_ready, 0);
        step();
        check("rerst_ready_high", st_ready, 1);
        underrun_expect(16'h0000, 16'h0000);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
